multiplier_control_unit: RTL

//   Sequencing FSM for the add-shift signed multiplier. Sits directly upstream of the 8-bit

---
 rtl/multiplier_control_unit_pkg.sv | 15 +
 rtl/multiplier_control_unit.sv | 89 ++++++++
 2 files changed

// File: rtl/multiplier_control_unit_pkg.sv
// Shared definitions for the add-shift signed multiplier: operand width and
// the control FSM state type used by the sequencer.
package mult_ctrl_pkg;

  localparam int MULT_N = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } mult_state_t;

endpackage

// File: rtl/multiplier_control_unit.sv
// Sequencer for the add-shift signed multiplier: clears A/X, runs N add/shift
// iterations (subtract on the last for two's-complement), then holds until Run drops.
module multiplier_control_unit
  import mult_ctrl_pkg::*;
#(
  parameter  int N     = MULT_N,
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic CLK,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_Ld,
  output logic ClearA,
  output logic Add,
  output logic Sub,
  output logic Shift_En,
  output logic Busy
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);

  mult_state_t      r_state;
  mult_state_t      w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST_ITER);

  // State and iteration counter; the counter saturates at the last iteration.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == START) begin
        r_cnt <= '0;
      end else if ((r_state == SHIFT) && !w_last) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    w_next_state = Run ? START : IDLE;
      START:   w_next_state = ADD;
      ADD:     w_next_state = SHIFT;
      SHIFT:   w_next_state = w_last ? HOLD : ADD;
      HOLD:    w_next_state = Run ? HOLD : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Reset masks every control strobe in the same cycle so a mid-run abort
  // never issues a stray add or shift to the datapath.
  always_comb begin
    Clr_Ld   = 1'b0;
    ClearA   = 1'b0;
    Add      = 1'b0;
    Sub      = 1'b0;
    Shift_En = 1'b0;
    Busy     = 1'b0;
    if (!Reset) begin
      unique case (r_state)
        IDLE: Clr_Ld = ClearA_LoadB;
        START: begin
          ClearA = 1'b1;
          Busy   = 1'b1;
        end
        ADD: begin
          Add  = M & ~w_last;
          Sub  = M &  w_last;
          Busy = 1'b1;
        end
        SHIFT: begin
          Shift_En = 1'b1;
          Busy     = 1'b1;
        end
        HOLD:    Busy = 1'b0;
        default: Busy = 1'b0;
      endcase
    end
  end

endmodule
